// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
// Elastic pipeline stage placed between two core pipeline stages. Words are
// accepted with an in_valid/in_ready handshake, held in a small circular
// buffer of DEPTH entries, and offered downstream with out_valid/out_ready.
// One transfer per cycle is sustained for every DEPTH. A flush empties the
// stage in a single cycle and drops the word offered that cycle.
//
// Parameters
//   DATA_W  payload width in bits (>= 1)
//   DEPTH   number of buffer entries (1..16, any value)
//   CNT_W   width of count, derived from DEPTH; leave at its default
//
// Ports
//   clk        rising-edge clock, the only clock
//   rst        synchronous, active-high reset; clears pointers and entries
//   flush      empty the stage and drop the current input word
//   in_valid   upstream presents a word
//   in_ready   stage accepts the presented word this cycle
//   in_data    upstream payload
//   out_valid  head entry is present
//   out_ready  downstream takes the head this cycle
//   out_data   head payload
//   count      number of buffered entries, 0..DEPTH

module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  // A single-entry buffer still needs a one-bit pointer so the array index
  // has a legal width; that pointer simply never leaves zero.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  // Pointers wrap at DEPTH rather than at a power of two, so odd depths are
  // handled without leaving holes in the array.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + PTR_W'(1);
    end
  endfunction

  // Output side is driven purely from stored state, so nothing on the input
  // side reaches out_valid/out_data in the same cycle.
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // A flush blocks the pop as well: whatever downstream signals that cycle,
  // the head is discarded, never delivered.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & ~flush;

  // With one entry the stage must accept a new word in the same cycle the
  // old one leaves, otherwise it would only reach half rate; that requires
  // looking at out_ready. Deeper stages reach full rate from their spare
  // entry and keep in_ready registered-only, which breaks the ready chain
  // across the pipeline.
  generate
    if (DEPTH == 1) begin : g_ready_single
      assign in_ready = ~rst & ~flush & ((count == '0) | out_ready);
    end else begin : g_ready_multi
      assign in_ready = ~rst & ~flush & (count < CNT_W'(DEPTH));
    end
  endgenerate

  // State update. Reset wins over flush; both empty the stage, but only
  // reset clears the stored words so out_data reads zero afterwards. Writes
  // happen only on an accepted push, and in_ready already guarantees a free
  // slot (or a slot being freed this cycle), so unread words are never
  // overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf
// Self-checking bench for pipe_stage_buf. Four instances (DEPTH 1, 2, 3, 4)
// share one set of input drivers; one instance at a time is selected and its
// outputs are compared every cycle against a queue-based model of the stage.
// Directed scenarios cover reset, streaming, backpressure, flush and the
// full single-entry push/pop case; random traffic covers pointer wrap,
// mid-stream reset and flush.

module tb_pipe_stage_buf;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              out_ready;
  logic [DATA_W-1:0] in_data;

  logic [3:0]             in_ready_v;
  logic [3:0]             out_valid_v;
  logic [3:0][DATA_W-1:0] out_data_v;
  logic [3:0][4:0]        count_v;

  always #5 clk = ~clk;

  // Instance g has DEPTH 1, 2, 3, 4 for g = 0..3; count is widened to a
  // common five bits so the checker can treat all instances alike.
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      localparam int D  = (g == 0) ? 1 : g + 1;
      localparam int CW = $clog2(D + 1);
      logic [CW-1:0]     cnt;
      logic              ir;
      logic              ov;
      logic [DATA_W-1:0] od;

      pipe_stage_buf #(.DATA_W(DATA_W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (ir),
        .in_data   (in_data),
        .out_valid (ov),
        .out_ready (out_ready),
        .out_data  (od),
        .count     (cnt)
      );

      assign in_ready_v[g]  = ir;
      assign out_valid_v[g] = ov;
      assign out_data_v[g]  = od;
      assign count_v[g]     = 5'(cnt);
    end
  endgenerate

  // Reference model: the buffered words in arrival order, plus a flag saying
  // storage was wiped by reset and nothing has been written since.
  int                sel;
  int                depth;
  logic [DATA_W-1:0] q[$];
  bit                cleared;
  int                total;
  int                bad;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s (depth %0d, t=%0t): got %h want %h",
               tag, depth, $time, obs, exp);
    end
  endtask

  // One cycle: drive inputs on the falling edge, compare outputs shortly
  // after, then advance the model to what the next rising edge must do.
  task automatic applyStimulus(input bit r, input bit f, input bit iv,
                               input logic [DATA_W-1:0] d, input bit ordy,
                               output bit acc);
    bit exp_ready;
    bit do_push;
    bit do_pop;
    @(negedge clk);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (depth == 1) begin
      exp_ready = !r && !f && (q.size() == 0 || ordy);
    end else begin
      exp_ready = !r && !f && (q.size() < depth);
    end
    checkOutput("in_ready", 64'(in_ready_v[sel]), 64'(exp_ready));
    checkOutput("out_valid", 64'(out_valid_v[sel]), 64'(q.size() != 0));
    checkOutput("count", 64'(count_v[sel]), 64'(q.size()));
    if (q.size() != 0) begin
      checkOutput("out_data", out_data_v[sel], q[0]);
    end else if (cleared) begin
      checkOutput("out_data_reset", out_data_v[sel], '0);
    end
    do_push = iv && exp_ready;
    do_pop  = (q.size() != 0) && ordy && !f;
    if (r) begin
      q.delete();
      cleared = 1'b1;
    end else if (f) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(d);
        cleared = 1'b0;
      end
    end
    acc = do_push;
  endtask

  // Switch to another instance and bring every instance to a known empty
  // state with an unchecked reset cycle.
  task automatic selectDut(input int k);
    sel   = k;
    depth = (k == 0) ? 1 : k + 1;
    @(negedge clk);
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    @(posedge clk);
    q.delete();
    cleared = 1'b1;
  endtask

  // Random traffic; upstream keeps offering the same word until it is taken.
  task automatic runRandom(input int k, input int cycles, input int flush_pct,
                           input int rst_pct);
    logic [DATA_W-1:0] word;
    bit                have;
    bit                acc;
    bit                r;
    bit                f;
    selectDut(k);
    have = 1'b0;
    word = '0;
    for (int i = 0; i < cycles; i++) begin
      if (!have && $urandom_range(0, 99) < 75) begin
        word = {$urandom, $urandom};
        have = 1'b1;
      end
      r = ($urandom_range(0, 99) < rst_pct);
      f = ($urandom_range(0, 99) < flush_pct);
      applyStimulus(r, f, have, word, 1'($urandom_range(0, 1)), acc);
      if (acc) have = 1'b0;
    end
  endtask

  logic [DATA_W-1:0] words [4];
  int                idx;
  bit                acc;

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);

    // Reset held three cycles with a word offered, then release.
    selectDut(1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);

    // Single-entry stage streaming 16 words at full rate.
    selectDut(0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 64'(i), 1'b1, acc);
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, acc);

    // Three-entry stage filled under backpressure, then drained.
    selectDut(2);
    words[0] = 64'hA;
    words[1] = 64'hB;
    words[2] = 64'hC;
    words[3] = 64'hD;
    idx = 0;
    repeat (6) begin
      applyStimulus(1'b0, 1'b0, idx < 4, (idx < 4) ? words[idx] : '0, 1'b0, acc);
      if (acc) idx++;
    end
    repeat (8) begin
      applyStimulus(1'b0, 1'b0, idx < 4, (idx < 4) ? words[idx] : '0, 1'b1, acc);
      if (acc) idx++;
    end

    // Flush drops two buffered words and the word offered alongside it.
    selectDut(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h11, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h22, 1'b0, acc);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h33, 1'b1, acc);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h44, 1'b0, acc);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, acc);

    // Single-entry stage full: push and pop in the same cycle.
    selectDut(0);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h54, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h55, 1'b1, acc);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, acc);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);

    // Random traffic: wrap-around on the three-entry stage, then every depth
    // with occasional flush and reset.
    runRandom(2, 80, 0, 0);
    for (int k = 0; k < 4; k++) begin
      runRandom(k, 150, 4, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
